// File: rtl/leaf_link_buffer.sv
// leaf_link_buffer: leaf-to-network packet FIFO with credit backpressure, downstream register and counters
module leaf_link_buffer #(
  parameter int PACKET_BITS = 97,
  parameter int FIFO_ADDR_BITS = 4,
  parameter int SKID = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] i_leaf_stream,
  output logic                   o_bft_ready,
  output logic [PACKET_BITS-1:0] o_net_stream,
  input  logic                   i_net_ready,
  input  logic [PACKET_BITS-1:0] i_net_stream,
  output logic [PACKET_BITS-1:0] o_leaf_stream,
  output logic [31:0]            o_tx_count,
  output logic [15:0]            o_drop_count
);
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  typedef logic [FIFO_ADDR_BITS:0] occ_t;
  typedef logic [FIFO_ADDR_BITS-1:0] ptr_t;
  logic [PACKET_BITS-1:0] ram [DEPTH];
  occ_t occ, occ_next;
  ptr_t wr_ptr, rd_ptr;
  logic in_v, head_v, pop, push, drop, ram_empty, head_load, rd, bypass, wr;
  always_comb begin
    in_v = i_leaf_stream[PACKET_BITS-1];
    head_v = o_net_stream[PACKET_BITS-1];
    pop = head_v & i_net_ready;
    push = in_v & ((int'(occ) < DEPTH) | pop);
    drop = in_v & !push;
    ram_empty = occ == occ_t'(head_v);
    head_load = !head_v | pop;
    rd = head_load & !ram_empty;
    bypass = head_load & ram_empty & push;
    wr = push & !bypass;
    occ_next = occ + occ_t'(push) - occ_t'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_net_stream <= '0;
      o_leaf_stream <= '0;
      o_bft_ready <= 1'b0;
      o_tx_count <= '0;
      o_drop_count <= '0;
    end else begin
      occ <= occ_next;
      wr_ptr <= wr ? wr_ptr + ptr_t'(1) : wr_ptr;
      rd_ptr <= rd ? rd_ptr + ptr_t'(1) : rd_ptr;
      o_net_stream <= !head_load ? o_net_stream : rd ? ram[rd_ptr] : bypass ? i_leaf_stream : '0;
      o_leaf_stream <= i_net_stream;
      o_bft_ready <= int'(occ_next) + SKID < DEPTH;
      o_tx_count <= pop ? o_tx_count + 32'd1 : o_tx_count;
      o_drop_count <= (drop && o_drop_count != 16'hFFFF) ? o_drop_count + 16'd1 : o_drop_count;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) ram[wr_ptr] <= i_leaf_stream;
  end
endmodule

// File: tb/tb_leaf_link_buffer.sv
// tb_leaf_link_buffer: directed and random scoreboard checks of leaf_link_buffer
module tb_leaf_link_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [96:0] i_leaf_stream = '0;
  logic [96:0] i_net_stream = '0;
  logic i_net_ready = 1'b0;
  logic o_bft_ready;
  logic [96:0] o_net_stream;
  logic [96:0] o_leaf_stream;
  logic [31:0] o_tx_count;
  logic [15:0] o_drop_count;
  int total = 0;
  int bad = 0;
  logic [96:0] q[$];
  logic [31:0] m_tx = '0;
  logic [15:0] m_drop = '0;
  always #5 clk = ~clk;
  leaf_link_buffer dut (
    .clk(clk),
    .reset(reset),
    .i_leaf_stream(i_leaf_stream),
    .o_bft_ready(o_bft_ready),
    .o_net_stream(o_net_stream),
    .i_net_ready(i_net_ready),
    .i_net_stream(i_net_stream),
    .o_leaf_stream(o_leaf_stream),
    .o_tx_count(o_tx_count),
    .o_drop_count(o_drop_count)
  );
  function automatic logic [96:0] pkt(input int t);
    return {1'b1, 96'(t)};
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cycle(input logic [96:0] leaf, input logic nr);
    logic p, a;
    i_leaf_stream = leaf;
    i_net_ready = nr;
    chk("head", o_net_stream, q.size() > 0 ? q[0] : '0);
    p = !reset && q.size() > 0 && nr;
    a = !reset && leaf[96] && (q.size() < 16 || p);
    if (p) begin
      void'(q.pop_front());
      m_tx++;
    end
    if (a) q.push_back(leaf);
    if (!reset && leaf[96] && !a) m_drop++;
    if (reset) begin
      q.delete();
      m_tx = '0;
      m_drop = '0;
    end
    @(posedge clk);
    #1;
    chk("bft_ready", o_bft_ready, !reset && q.size() + 2 < 16);
  endtask
  initial begin
    logic v, r1, r2, r3;
    int sent;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_head", o_net_stream, '0);
    chk("reset_tx", o_tx_count, '0);
    chk("reset_drop", o_drop_count, '0);
    chk("reset_ready", o_bft_ready, 1'b0);
    chk("reset_leaf", o_leaf_stream, '0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", o_bft_ready, 1'b1);
    cycle(pkt(32'hAB), 1'b1);
    chk("single_head", o_net_stream, {1'b1, 96'hAB});
    cycle('0, 1'b1);
    chk("single_empty", o_net_stream, '0);
    chk("single_tx", o_tx_count, 32'd1);
    for (int k = 1; k <= 17; k++) begin
      cycle(pkt(k), 1'b0);
      if (k == 13) chk("ready_after_13", o_bft_ready, 1'b1);
      if (k == 14) chk("ready_after_14", o_bft_ready, 1'b0);
    end
    chk("fill_drop", o_drop_count, 16'd1);
    chk("fill_head", o_net_stream, pkt(1));
    cycle(pkt(18), 1'b1);
    chk("full_push_pop_drop", o_drop_count, 16'd1);
    cycle(pkt(19), 1'b0);
    chk("still_full_drop", o_drop_count, 16'd2);
    i_net_stream = 97'h1_0000_0000_0000_0000_0000_0055;
    cycle('0, 1'b0);
    chk("downstream_a", o_leaf_stream, 97'h1_0000_0000_0000_0000_0000_0055);
    i_net_stream = 97'h0_1234_5678_9ABC_DEF0_0F0F_AA55;
    cycle('0, 1'b0);
    chk("downstream_b", o_leaf_stream, 97'h0_1234_5678_9ABC_DEF0_0F0F_AA55);
    repeat (20) cycle('0, 1'b1);
    chk("drain_tx", o_tx_count, 32'd18);
    chk("drain_tx_model", o_tx_count, m_tx);
    chk("drain_drop", o_drop_count, m_drop);
    cycle(pkt(100), 1'b0);
    cycle(pkt(101), 1'b1);
    chk("occ1_replace", o_net_stream, pkt(101));
    cycle('0, 1'b1);
    chk("occ1_tx", o_tx_count, 32'd20);
    for (int k = 0; k < 9; k++) cycle(pkt(200 + k), 1'b0);
    reset = 1'b1;
    cycle('0, 1'b0);
    reset = 1'b0;
    chk("midreset_head", o_net_stream, '0);
    chk("midreset_tx", o_tx_count, '0);
    chk("midreset_drop", o_drop_count, '0);
    chk("midreset_ready", o_bft_ready, 1'b0);
    chk("midreset_leaf", o_leaf_stream, '0);
    cycle('0, 1'b1);
    chk("midreset_ready_back", o_bft_ready, 1'b1);
    repeat (4) cycle('0, 1'b1);
    chk("midreset_no_stale", o_tx_count, '0);
    sent = 0;
    r1 = 1'b1;
    r2 = 1'b1;
    r3 = 1'b1;
    for (int c = 0; c < 20000 && (sent < 1000 || q.size() > 0); c++) begin
      r3 = r2;
      r2 = r1;
      r1 = o_bft_ready;
      v = sent < 1000 && r3 && $urandom_range(0, 1) == 1;
      cycle(v ? pkt(5000 + sent) : '0, $urandom_range(0, 3) != 0);
      if (v) sent++;
    end
    chk("stress_sent", sent, 1000);
    chk("stress_drained", q.size(), 0);
    chk("stress_drop", o_drop_count, '0);
    chk("stress_tx", o_tx_count, 32'd1000);
    chk("stress_head", o_net_stream, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
